// File: rtl/join_n.sv
// join_n: N-channel stream join.
// Each input channel has its own small FIFO. When every enabled channel holds
// at least one beat, one beat is taken from each and presented as a single
// concatenated output beat through a registered valid/ready stage.
// Lanes of disabled channels are driven to zero. Disabled channels are never
// popped, but they keep buffering input until their FIFO is full.
module join_n #(
  parameter int NCH   = 2,
  parameter int DW    = 11,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    i_valid,
  output logic [NCH-1:0]    i_ready,
  input  logic [NCH*DW-1:0] i_data,
  input  logic [NCH-1:0]    i_mask,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [NCH*DW-1:0] o_data,
  output logic [CW-1:0]     o_join_cnt
);

  // Pointer width is held at one bit or more so that DEPTH=1 still has a
  // legal (always zero) pointer.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // FIFO storage and bookkeeping, one set per channel
  logic [DW-1:0] mem_q    [NCH][DEPTH];
  logic [DW-1:0] mem_d    [NCH][DEPTH];
  logic [PW-1:0] wr_ptr_q [NCH];
  logic [PW-1:0] wr_ptr_d [NCH];
  logic [PW-1:0] rd_ptr_q [NCH];
  logic [PW-1:0] rd_ptr_d [NCH];
  logic [OW-1:0] occ_q    [NCH];
  logic [OW-1:0] occ_d    [NCH];

  // Output stage and join counter
  logic              o_valid_q;
  logic              o_valid_d;
  logic [NCH*DW-1:0] o_data_q;
  logic [NCH*DW-1:0] o_data_d;
  logic [CW-1:0]     join_cnt_q;
  logic [CW-1:0]     join_cnt_d;

  // Derived per-channel status
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    pop;
  logic [NCH*DW-1:0] head_lanes;
  logic              heads_ready;
  logic              out_free;
  logic              join_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Per-channel full/empty flags and the FIFO head for each lane
  always_comb begin
    full       = '0;
    empty      = '0;
    head_lanes = '0;
    for (int c = 0; c < NCH; c++) begin
      full[c]                = (occ_q[c] == OCC_FULL);
      empty[c]               = (occ_q[c] == '0);
      head_lanes[c*DW +: DW] = mem_q[c][rd_ptr_q[c]];
    end
  end

  // Input readiness depends only on FIFO fill level and reset, never on valid
  always_comb begin
    i_ready = {NCH{~rst}} & ~full;
  end

  // Join decision: every enabled channel has a head beat and the output can take it
  always_comb begin
    heads_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (i_mask[c] && empty[c]) begin
        heads_ready = 1'b0;
      end
    end
    out_free = !o_valid_q || o_ready;
    join_ok  = (|i_mask) && heads_ready && out_free;
  end

  // Handshake strobes: push on accepted input, pop only enabled channels on a join
  always_comb begin
    push = i_valid & i_ready;
    pop  = {NCH{join_ok}} & i_mask;
  end

  // FIFO next state: write at wr_ptr, read at rd_ptr, occupancy tracks net change
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = i_data[c*DW +: DW];
        wr_ptr_d[c]           = ptr_inc(wr_ptr_q[c]);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
      end
      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + OW'(1);
        2'b01:   occ_d[c] = occ_q[c] - OW'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  // Output register: load on join (disabled lanes zeroed), hold while stalled,
  // drop valid once the beat is taken and nothing new replaces it
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    if (join_ok) begin
      o_valid_d = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        o_data_d[c*DW +: DW] = i_mask[c] ? head_lanes[c*DW +: DW] : '0;
      end
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Join counter counts beats accepted downstream and wraps naturally
  always_comb begin
    join_cnt_d = join_cnt_q;
    if (o_valid_q && o_ready) begin
      join_cnt_d = join_cnt_q + CW'(1);
    end
  end

  // FIFO state registers; reset discards all buffered beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[c][k] <= '0;
        end
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[c][k] <= mem_d[c][k];
        end
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        occ_q[c]    <= occ_d[c];
      end
    end
  end

  // Output stage and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      join_cnt_q <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      join_cnt_q <= join_cnt_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_join_cnt = join_cnt_q;

endmodule
